game_ctrl: RTL and testbench

Round controller for the game top level. It sequences the game through idle, playing, paused and game-over states from debounced key presses and the frame strobe. It also owns the round countdown, score and lives, which drive the HEX/LEDR display logic. The hit/miss datapath only reports events; this block decides whether they count.

---
 rtl/game_pkg.sv | 19 +
 rtl/game_ctrl_key_edge.sv | 31 +++
 rtl/game_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_game_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game round controller and the display logic.
//   game_state_t : two-bit game state encoding (IDLE=00, PLAYING=01, PAUSED=11, GAME_OVER=10)
//   SCORE_MAX    : score saturation limit, chosen so three decimal digits always suffice
//   KEY_START / KEY_PAUSE : bit positions of the start/restart and pause/resume keys
package game_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_PLAYING   = 2'b01,
        S_GAME_OVER = 2'b10,
        S_PAUSED    = 2'b11
    } game_state_t;

    localparam logic [9:0] SCORE_MAX = 10'd999;

    localparam int unsigned KEY_START = 0;
    localparam int unsigned KEY_PAUSE = 1;

endpackage

// File: rtl/game_ctrl_key_edge.sv
// key_edge: 4-bit registered falling-edge detector for debounced, active-low keys.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   key_n  in  [3:0] debounced, synchronized keys, low = pressed
//   press  out [3:0] one-cycle pulse per key press (falling edge of key_n)
// A key held through reset release produces no press until it is released and
// pressed again: detection is disarmed for the first clock after reset.
module key_edge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    output logic [3:0] press
);

    logic [3:0] key_prev;
    logic       armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev <= 4'b1111;
            armed    <= 1'b0;
        end else begin
            key_prev <= key_n;
            armed    <= 1'b1;
        end
    end

    // The first clock after reset only captures the key levels.
    assign press = armed ? (key_prev & ~key_n) : 4'b0000;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: round controller for the game top level.
// Sequences IDLE / PLAYING / PAUSED / GAME_OVER from key presses and owns the round
// countdown, score and lives. hit/miss/frame only count while PLAYING.
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   frame        in  one-cycle strobe per video frame
//   key_n        in  [3:0] debounced active-low keys; [0]=start/restart, [1]=pause/resume
//   hit          in  one-cycle scoring event
//   miss         in  one-cycle life-loss event
//   state        out [1:0] current game state (game_pkg encoding)
//   time_left    out [6:0] seconds remaining
//   score        out [9:0] score, saturating at SCORE_MAX
//   lives        out [1:0] lives remaining
//   round_active out high only in PLAYING
//   over_pulse   out one-cycle pulse on entry to GAME_OVER
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned ROUND_SECONDS  = 30,
    parameter int unsigned LIVES          = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame,
    input  logic [3:0] key_n,
    input  logic       hit,
    input  logic       miss,
    output logic [1:0] state,
    output logic [6:0] time_left,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic       round_active,
    output logic       over_pulse
);

    localparam logic [9:0] FRAME_LAST = 10'(FRAMES_PER_SEC - 1);
    localparam logic [6:0] TIME_INIT  = 7'(ROUND_SECONDS);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    logic [3:0]  press;
    logic        start_press;
    logic        pause_press;
    logic        unused_keys;

    game_state_t cur_state;
    logic [9:0]  frame_cnt;

    // Candidate PLAYING-state updates, applied only when the FSM is in PLAYING.
    logic [9:0]  score_nxt;
    logic [1:0]  lives_nxt;
    logic [6:0]  time_nxt;
    logic [9:0]  frame_nxt;
    logic        sec_tick;
    logic        round_end;

    key_edge u_key_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_n),
        .press (press)
    );

    assign start_press = press[KEY_START];
    assign pause_press = press[KEY_PAUSE];
    assign unused_keys = ^press[3:2];

    always_comb begin
        score_nxt = score;
        lives_nxt = lives;
        time_nxt  = time_left;
        frame_nxt = frame_cnt;
        sec_tick  = 1'b0;

        if (hit && (score < SCORE_MAX)) begin
            score_nxt = score + 10'd1;
        end
        if (miss && (lives != 2'd0)) begin
            lives_nxt = lives - 2'd1;
        end
        if (frame) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_nxt = 10'd0;
                sec_tick  = 1'b1;
            end else begin
                frame_nxt = frame_cnt + 10'd1;
            end
        end
        if (sec_tick && (time_left != 7'd0)) begin
            time_nxt = time_left - 7'd1;
        end

        // Lives and time running out together still make a single round end.
        round_end = (lives_nxt == 2'd0) || (time_nxt == 7'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= S_IDLE;
            time_left    <= 7'd0;
            score        <= 10'd0;
            lives        <= 2'd0;
            frame_cnt    <= 10'd0;
            round_active <= 1'b0;
            over_pulse   <= 1'b0;
        end else begin
            over_pulse <= 1'b0;
            unique case (cur_state)
                S_IDLE: begin
                    if (start_press) begin
                        cur_state    <= S_PLAYING;
                        time_left    <= TIME_INIT;
                        score        <= 10'd0;
                        lives        <= LIVES_INIT;
                        frame_cnt    <= 10'd0;
                        round_active <= 1'b1;
                    end
                end

                S_PLAYING: begin
                    if (start_press) begin
                        // Restart wins over pause and over any same-cycle event.
                        time_left    <= TIME_INIT;
                        score        <= 10'd0;
                        lives        <= LIVES_INIT;
                        frame_cnt    <= 10'd0;
                        round_active <= 1'b1;
                    end else begin
                        // Counters always take the update, including on the
                        // GAME_OVER-entry and PAUSED-entry cycles.
                        time_left <= time_nxt;
                        score     <= score_nxt;
                        lives     <= lives_nxt;
                        frame_cnt <= frame_nxt;
                        if (round_end) begin
                            cur_state    <= S_GAME_OVER;
                            round_active <= 1'b0;
                            over_pulse   <= 1'b1;
                        end else if (pause_press) begin
                            cur_state    <= S_PAUSED;
                            round_active <= 1'b0;
                        end
                    end
                end

                S_PAUSED: begin
                    if (start_press) begin
                        cur_state    <= S_PLAYING;
                        time_left    <= TIME_INIT;
                        score        <= 10'd0;
                        lives        <= LIVES_INIT;
                        frame_cnt    <= 10'd0;
                        round_active <= 1'b1;
                    end else if (pause_press) begin
                        cur_state    <= S_PLAYING;
                        round_active <= 1'b1;
                    end
                end

                S_GAME_OVER: begin
                    if (start_press) begin
                        cur_state    <= S_PLAYING;
                        time_left    <= TIME_INIT;
                        score        <= 10'd0;
                        lives        <= LIVES_INIT;
                        frame_cnt    <= 10'd0;
                        round_active <= 1'b1;
                    end
                end

                default: begin
                    cur_state    <= S_IDLE;
                    round_active <= 1'b0;
                end
            endcase
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;
    import game_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       frame;
    logic [3:0] key_n;
    logic       hit;
    logic       miss;
    logic [1:0] state;
    logic [6:0] time_left;
    logic [9:0] score;
    logic [1:0] lives;
    logic       round_active;
    logic       over_pulse;

    int n_cmp;
    int n_bad;
    int n_over;

    game_ctrl #(
        .FRAMES_PER_SEC (60),
        .ROUND_SECONDS  (30),
        .LIVES          (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame        (frame),
        .key_n        (key_n),
        .hit          (hit),
        .miss         (miss),
        .state        (state),
        .time_left    (time_left),
        .score        (score),
        .lives        (lives),
        .round_active (round_active),
        .over_pulse   (over_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] k;
        logic       h;
        logic       m;
        logic       f;
        logic [1:0] st;
        logic [6:0] t;
        logic [9:0] s;
        logic [1:0] l;
        logic       ra;
        logic       op;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic [3:0] k, input logic h, input logic m, input logic f,
                     input logic [1:0] st, input int t, input int s, input int l,
                     input logic ra, input logic op);
        vec_t x;
        x.k = k; x.h = h; x.m = m; x.f = f;
        x.st = st; x.t = 7'(t); x.s = 10'(s); x.l = 2'(l); x.ra = ra; x.op = op;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] st, input int t, input int s,
                           input int l, input logic ra, input logic op);
        chk({name, ".state"}, int'(state), int'(st));
        chk({name, ".time_left"}, int'(time_left), t);
        chk({name, ".score"}, int'(score), s);
        chk({name, ".lives"}, int'(lives), l);
        chk({name, ".round_active"}, int'(round_active), int'(ra));
        chk({name, ".over_pulse"}, int'(over_pulse), int'(op));
    endtask

    // One clock: drive at negedge, sample 1 time unit after the posedge.
    task automatic step(input logic [3:0] k, input logic h, input logic m, input logic f);
        @(negedge clk);
        key_n = k; hit = h; miss = m; frame = f;
        @(posedge clk);
        #1;
        hit = 1'b0; miss = 1'b0; frame = 1'b0;
        if (over_pulse) n_over++;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(4'hF, 1'b0, 1'b0, 1'b1);
    endtask

    localparam logic [1:0] I = 2'b00, P = 2'b01, Z = 2'b11, G = 2'b10;

    initial begin
        n_cmp = 0; n_bad = 0; n_over = 0;
        rst_n = 1'b0; key_n = 4'hF; hit = 1'b0; miss = 1'b0; frame = 1'b0;
        #1;
        chk_all("reset", I, 0, 0, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //  key   h     m     f     st t   s  l  ra    op
        v(4'hF, 1'b0, 1'b0, 1'b0, I, 0,  0, 0, 1'b0, 1'b0); // idle, arms edge detector
        v(4'hF, 1'b1, 1'b1, 1'b1, I, 0,  0, 0, 1'b0, 1'b0); // events ignored in IDLE
        v(4'hE, 1'b0, 1'b0, 1'b0, P, 30, 0, 3, 1'b1, 1'b0); // start press
        v(4'hE, 1'b1, 1'b0, 1'b0, P, 30, 1, 3, 1'b1, 1'b0); // held start: no restart
        v(4'hF, 1'b1, 1'b0, 1'b0, P, 30, 2, 3, 1'b1, 1'b0);
        v(4'hF, 1'b1, 1'b1, 1'b0, P, 30, 3, 2, 1'b1, 1'b0); // hit+miss together
        v(4'hF, 1'b0, 1'b0, 1'b1, P, 30, 3, 2, 1'b1, 1'b0);
        v(4'hD, 1'b0, 1'b0, 1'b0, Z, 30, 3, 2, 1'b0, 1'b0); // pause
        v(4'hF, 1'b1, 1'b1, 1'b1, Z, 30, 3, 2, 1'b0, 1'b0); // ignored while paused
        v(4'hD, 1'b0, 1'b0, 1'b0, P, 30, 3, 2, 1'b1, 1'b0); // resume
        v(4'hF, 1'b0, 1'b1, 1'b0, P, 30, 3, 1, 1'b1, 1'b0);
        v(4'hF, 1'b0, 1'b1, 1'b0, G, 30, 3, 0, 1'b0, 1'b1); // last life -> GAME_OVER
        v(4'hF, 1'b1, 1'b1, 1'b1, G, 30, 3, 0, 1'b0, 1'b0); // frozen, pulse gone
        v(4'hE, 1'b0, 1'b0, 1'b0, P, 30, 0, 3, 1'b1, 1'b0); // restart from GAME_OVER
        v(4'hF, 1'b1, 1'b0, 1'b0, P, 30, 1, 3, 1'b1, 1'b0);
        v(4'hC, 1'b1, 1'b0, 1'b0, P, 30, 0, 3, 1'b1, 1'b0); // start+pause: restart wins
        v(4'hF, 1'b1, 1'b1, 1'b0, P, 30, 1, 2, 1'b1, 1'b0);
        v(4'hF, 1'b1, 1'b1, 1'b0, P, 30, 2, 1, 1'b1, 1'b0); // hit+miss at lives=2

        foreach (vecs[i]) begin
            step(vecs[i].k, vecs[i].h, vecs[i].m, vecs[i].f);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].t, vecs[i].s, vecs[i].l,
                    vecs[i].ra, vecs[i].op);
        end

        // Countdown with pause, including pause on the decrement cycle.
        step(4'hE, 1'b0, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0, 1'b0);
        frames(59);
        chk_all("cd_59", P, 30, 0, 3, 1'b1, 1'b0);
        step(4'hD, 1'b0, 1'b0, 1'b1);
        chk_all("cd_pause_on_tick", Z, 29, 0, 3, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(4'hF, 1'b1, 1'b1, 1'b1);
        chk_all("cd_paused_hold", Z, 29, 0, 3, 1'b0, 1'b0);
        step(4'hD, 1'b0, 1'b0, 1'b0);
        frames(30);
        step(4'hD, 1'b0, 1'b0, 1'b0);
        chk("cd_pause2.state", int'(state), int'(Z));
        frames(50);
        step(4'hD, 1'b0, 1'b0, 1'b0);
        frames(29);
        chk_all("cd_partial_kept", P, 29, 0, 3, 1'b1, 1'b0);
        frames(1);
        chk_all("cd_second2", P, 28, 0, 3, 1'b1, 1'b0);

        // Last miss coincides with time expiry, with a hit on the same cycle.
        step(4'hF, 1'b0, 1'b1, 1'b0);
        step(4'hF, 1'b0, 1'b1, 1'b0);
        frames(27 * 60);
        chk_all("both_t1", P, 1, 0, 1, 1'b1, 1'b0);
        frames(59);
        n_over = 0;
        step(4'hF, 1'b1, 1'b1, 1'b1);
        chk_all("both_end", G, 0, 1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'hF, 1'b1, 1'b1, 1'b1);
        chk_all("both_frozen", G, 0, 1, 0, 1'b0, 1'b0);
        chk("both_over_count", n_over, 1);

        // Full round on time alone: 1800 frames.
        step(4'hE, 1'b0, 1'b0, 1'b0);
        chk_all("time_restart", P, 30, 0, 3, 1'b1, 1'b0);
        n_over = 0;
        frames(1799);
        chk_all("time_1799", P, 1, 0, 3, 1'b1, 1'b0);
        frames(1);
        chk_all("time_1800", G, 0, 0, 3, 1'b0, 1'b1);
        frames(10);
        chk_all("time_frozen", G, 0, 0, 3, 1'b0, 1'b0);
        chk("time_over_count", n_over, 1);

        // Score saturation.
        step(4'hE, 1'b0, 1'b0, 1'b0);
        chk_all("sat_restart", P, 30, 0, 3, 1'b1, 1'b0);
        for (int i = 0; i < 998; i++) step(4'hF, 1'b1, 1'b0, 1'b0);
        chk("sat_998", int'(score), 998);
        step(4'hF, 1'b1, 1'b0, 1'b0);
        chk("sat_999", int'(score), 999);
        for (int i = 0; i < 6; i++) step(4'hF, 1'b1, 1'b0, 1'b0);
        chk_all("sat_1005", P, 30, 999, 3, 1'b1, 1'b0);

        // Asynchronous reset mid-round with start held through release.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        key_n = 4'hE;
        #1;
        chk_all("async_rst", I, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(4'hE, 1'b0, 1'b0, 1'b0);
        chk_all("held_thru_rst", I, 0, 0, 0, 1'b0, 1'b0);
        step(4'hF, 1'b0, 1'b0, 1'b0);
        chk("released.state", int'(state), int'(I));
        step(4'hE, 1'b0, 1'b0, 1'b0);
        chk_all("repress", P, 30, 0, 3, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
